// File: rtl/strobe_seq_pkg.sv
// Shared types for the strobe select sequencer:
// FSM state encoding, phase counter width and the queued request record.
package strobe_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [2:0]       sel;
    logic [CNT_W-1:0] len;
  } req_t;

endpackage

// File: rtl/strobe_req_fifo.sv
// Synchronous request FIFO, wrap-bit pointers, registered not-full ready.
// A pop in the same cycle never lets a push into a full FIFO.
module strobe_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         ready
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic [AW:0]  wp_d;
  logic [AW:0]  rp_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         ready_q;
  logic         do_push;
  logic         do_pop;
  logic         full_d;

  assign do_push = push && ready_q;
  assign do_pop  = pop && !empty;
  assign wp_d    = wp_q + {{AW{1'b0}}, do_push};
  assign rp_d    = rp_q + {{AW{1'b0}}, do_pop};
  assign full_d  = (wp_d[AW] != rp_d[AW]) &&
                   (wp_d[AW-1:0] == rp_d[AW-1:0]);
  assign empty   = wp_q == rp_q;
  assign rdata   = mem_q[rp_q[AW-1:0]];
  assign ready   = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ready_q <= !full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wp_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/strobe_sel_seq.sv
// Timed select/enable sequencer for a 3-to-8 active-low strobe decoder.
// Select only moves while enable is low: setup, strobe, then hold.
module strobe_sel_seq
  import strobe_seq_pkg::*;
#(
  parameter int SETUP = 1,
  parameter int HOLD  = 1,
  parameter int DEPTH = 2,
  parameter int LENW  = 4
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_sel,
  input  logic [LENW-1:0] req_len,
  output logic            dec_a,
  output logic            dec_b,
  output logic            dec_c,
  output logic            dec_en,
  output logic            busy,
  output logic            done
);

  localparam int W = 3 + LENW;
  localparam logic [CNT_W-1:0] SETUP_C = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD > 0 ? HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [2:0]       sel_q;
  logic             en_q;
  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     fifo_rd;
  logic             fifo_empty;
  req_t             head;
  logic             last;
  logic             end_req;
  logic             pop;

  strobe_req_fifo #(
    .DEPTH(DEPTH),
    .W    (W)
  ) u_fifo (
    .clk  (sys_clk),
    .rst  (rst),
    .push (req_valid),
    .wdata({req_sel, req_len}),
    .pop  (pop),
    .rdata(fifo_rd),
    .empty(fifo_empty),
    .ready(req_ready)
  );

  assign head.sel = fifo_rd[W-1 -: 3];
  assign head.len = CNT_W'(fifo_rd[LENW-1:0]);

  assign last    = cnt_q == '0;
  assign end_req = last && ((state_q == ST_HOLD) ||
                   (state_q == ST_STROBE && HOLD == 0));
  // The next request is taken either from idle or straight off the end.
  assign pop     = !fifo_empty && (state_q == ST_IDLE || end_req);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= end_req;
      if (pop) begin
        state_q <= ST_SETUP;
        sel_q   <= head.sel;
        len_q   <= head.len;
        cnt_q   <= SETUP_C;
        en_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_SETUP: begin
            if (last) begin
              state_q <= ST_STROBE;
              cnt_q   <= len_q;
              en_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          ST_STROBE: begin
            if (!last) begin
              cnt_q <= cnt_q - ONE;
            end else if (HOLD == 0) begin
              en_q    <= 1'b0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              en_q    <= 1'b0;
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_C;
            end
          end
          ST_HOLD: begin
            if (last) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dec_a  = sel_q[0];
  assign dec_b  = sel_q[1];
  assign dec_c  = sel_q[2];
  assign dec_en = en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
